// File: rtl/mux_arbiter_rr_if.sv
// Handshake bundle for mux_arbiter_rr: N requester channels in, one
// registered output channel out, plus the index of the held word.
interface mux_arbiter_rr_if #(
    parameter int N  = 4,
    parameter int W  = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
);
    logic [N-1:0]   req_vld;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_rdy;
    logic           out_vld;
    logic [W-1:0]   out_data;
    logic           out_rdy;
    logic [IW-1:0]  grant_idx;

    modport master (
        output req_vld,
        output req_data,
        input  req_rdy,
        input  out_vld,
        input  out_data,
        output out_rdy,
        input  grant_idx
    );

    modport slave (
        input  req_vld,
        input  req_data,
        output req_rdy,
        output out_vld,
        output out_data,
        input  out_rdy,
        output grant_idx
    );
endinterface

// File: rtl/mux_arbiter_rr.sv
// Round-robin N:1 arbiter feeding a single registered output channel.
// Define MUX_ARB_FIXED_PRIO_EN for lowest-index-wins fixed priority.
module mux_arbiter_rr #(
    parameter int N  = 4,
    parameter int W  = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    mux_arbiter_rr_if.slave   bus_io
);

    logic          load_en;
    logic          any_vld;
    logic [IW-1:0] sel;
    logic [N-1:0]  rdy;

    logic          out_vld_q;
    logic          out_vld_d;
    logic [W-1:0]  out_data_q;
    logic [W-1:0]  out_data_d;
    logic [IW-1:0] grant_q;
    logic [IW-1:0] grant_d;

    // Output register may take a new word when empty or draining now.
    assign load_en = !out_vld_q || bus_io.out_rdy;
    assign any_vld = |bus_io.req_vld;

`ifdef MUX_ARB_FIXED_PRIO_EN

    // Lowest valid index always wins; no rotation state is kept.
    always_comb begin
        sel = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus_io.req_vld[i]) begin
                sel = IW'(i);
            end
        end
    end

`else

    logic [IW-1:0] last_q;
    logic [IW-1:0] last_d;
    logic          hit;

    function automatic logic [IW-1:0] wrap_idx(
        input logic [IW-1:0] base,
        input int            off
    );
        int s;
        s = int'(base) + off;
        if (s >= N) begin
            s = s - N;
        end
        return IW'(s);
    endfunction

    // Scan upward from the slot after the last grant, wrapping at N.
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!hit && bus_io.req_vld[wrap_idx(last_q, k)]) begin
                hit = 1'b1;
                sel = wrap_idx(last_q, k);
            end
        end
    end

    // Pointer moves only when a word is actually taken.
    always_comb begin
        last_d = last_q;
        if (load_en && any_vld) begin
            last_d = sel;
        end
    end

    // Reset points at N-1 so the first grant favours index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= IW'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

`endif

    // Acknowledge only the selected requester, never during reset.
    always_comb begin
        rdy = '0;
        if (!rst && load_en && any_vld) begin
            rdy[sel] = 1'b1;
        end
    end

    // Load the muxed word on a transfer, or empty on an idle drain.
    always_comb begin
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        grant_d    = grant_q;
        if (load_en) begin
            if (any_vld) begin
                out_vld_d  = 1'b1;
                out_data_d = bus_io.req_data[int'(sel) * W +: W];
                grant_d    = sel;
            end else begin
                out_vld_d  = 1'b0;
            end
        end
    end

    // Output register; reset drops any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            grant_q    <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            grant_q    <= grant_d;
        end
    end

    assign bus_io.req_rdy   = rdy;
    assign bus_io.out_vld   = out_vld_q;
    assign bus_io.out_data  = out_data_q;
    assign bus_io.grant_idx = grant_q;

endmodule

// File: tb/tb_mux_arbiter_rr.sv
// Self-checking bench for mux_arbiter_rr: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_mux_arbiter_rr;

    localparam int N = 4;
    localparam int W = 8;

`ifdef MUX_ARB_FIXED_PRIO_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mux_arbiter_rr_if #(.N(N), .W(W)) bus ();

    mux_arbiter_rr #(.N(N), .W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    int checks = 0;
    int errors = 0;

    bit           m_known = 1'b0;
    bit           m_vld;
    logic [W-1:0] m_data;
    int           m_gidx;
    int           m_last;
    logic [N-1:0] obs_rdy;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    // Winner: first valid entry in the priority order for this cycle.
    function automatic int pick(input logic [N-1:0] vld, input int last);
        int order[$];
        if (FP) begin
            for (int i = 0; i < N; i++) order.push_back(i);
        end else begin
            for (int i = 1; i <= N; i++) order.push_back((last + i) % N);
        end
        foreach (order[k]) begin
            if (vld[order[k]]) return order[k];
        end
        return -1;
    endfunction

    function automatic logic [N*W-1:0] idx_data(input int base);
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = W'(base + i);
        return d;
    endfunction

    // One clock: drive at negedge, compare against model, advance model.
    task automatic cyc(input logic [N-1:0] vld, input logic [N*W-1:0] data,
                       input bit ordy, input bit r);
        int           s;
        bit           load;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        rst          = r;
        bus.req_vld  = vld;
        bus.req_data = data;
        bus.out_rdy  = ordy;
        #1;
        obs_rdy = bus.req_rdy;
        load    = !m_vld || ordy;
        s       = pick(vld, m_last);
        exp_rdy = '0;
        if (!r && m_known && load && s >= 0) exp_rdy[s] = 1'b1;
        check("req_rdy", 32'(obs_rdy), 32'(exp_rdy));
        if (m_known) begin
            check("out_vld", 32'(bus.out_vld), 32'(m_vld));
            check("out_data", 32'(bus.out_data), 32'(m_data));
            check("grant_idx", 32'(bus.grant_idx), 32'(m_gidx));
        end
        @(posedge clk);
        if (r) begin
            m_known = 1'b1;
            m_vld   = 1'b0;
            m_data  = '0;
            m_gidx  = 0;
            m_last  = N - 1;
        end else if (load) begin
            if (s >= 0) begin
                m_vld  = 1'b1;
                m_data = data[s*W +: W];
                m_gidx = s;
                m_last = s;
            end else begin
                m_vld = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        logic [N*W-1:0] d;
        rst          = 1'b1;
        bus.req_vld  = '0;
        bus.req_data = '0;
        bus.out_rdy  = 1'b0;
        m_vld        = 1'b0;
        m_data       = '0;
        m_gidx       = 0;
        m_last       = N - 1;

        // Reset state
        cyc('0, '0, 1'b1, 1'b1);
        check("rst_rdy", 32'(obs_rdy), 32'h0);
        check("rst_vld", 32'(bus.out_vld), 32'h0);
        check("rst_data", 32'(bus.out_data), 32'h0);
        check("rst_gidx", 32'(bus.grant_idx), 32'h0);

        // Single requester
        d = '0;
        d[2*W +: W] = 8'hA5;
        cyc(4'b0100, d, 1'b1, 1'b0);
        check("single_rdy", 32'(obs_rdy), 32'b0100);
        check("single_vld", 32'(bus.out_vld), 32'h1);
        check("single_data", 32'(bus.out_data), 32'hA5);
        check("single_gidx", 32'(bus.grant_idx), 32'h2);

        // All valid back to back from a fresh reset
        cyc('0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc(4'b1111, idx_data(0), 1'b1, 1'b0);
            check("rr_gidx", 32'(bus.grant_idx), FP ? 32'h0 : 32'(i % 4));
            check("rr_data", 32'(bus.out_data), FP ? 32'h0 : 32'(i % 4));
            check("rr_vld", 32'(bus.out_vld), 32'h1);
        end

        // Backpressure
        cyc(4'b0010, idx_data(8'h10), 1'b1, 1'b0);
        check("bp_load", 32'(bus.grant_idx), 32'h1);
        for (int i = 0; i < 3; i++) begin
            cyc(4'b1111, idx_data(8'h20), 1'b0, 1'b0);
            check("bp_rdy", 32'(obs_rdy), 32'h0);
            check("bp_gidx", 32'(bus.grant_idx), 32'h1);
            check("bp_data", 32'(bus.out_data), 32'h11);
        end
        cyc(4'b1111, idx_data(8'h20), 1'b1, 1'b0);
        check("bp_rel_rdy", 32'(obs_rdy), FP ? 32'b0001 : 32'b0100);
        check("bp_rel_gidx", 32'(bus.grant_idx), FP ? 32'h0 : 32'h2);

        // Wrap and skip
        cyc(4'b1000, idx_data(0), 1'b1, 1'b0);
        check("wrap_pre", 32'(bus.grant_idx), 32'h3);
        cyc(4'b1010, idx_data(0), 1'b1, 1'b0);
        check("wrap_g0", 32'(bus.grant_idx), 32'h1);
        cyc(4'b1010, idx_data(0), 1'b1, 1'b0);
        check("wrap_g1", 32'(bus.grant_idx), FP ? 32'h1 : 32'h3);
        cyc(4'b1010, idx_data(0), 1'b1, 1'b0);
        check("wrap_g2", 32'(bus.grant_idx), 32'h1);

        // Drain with no requesters; pointer must stay at 1
        cyc('0, '0, 1'b1, 1'b0);
        check("drain_vld", 32'(bus.out_vld), 32'h0);
        check("drain_gidx", 32'(bus.grant_idx), 32'h1);
        cyc(4'b1111, idx_data(0), 1'b1, 1'b0);
        check("drain_next", 32'(bus.grant_idx), FP ? 32'h0 : 32'h2);

        // Reset mid-stream drops the held word
        cyc(4'b1111, idx_data(0), 1'b0, 1'b1);
        check("mrst_rdy", 32'(obs_rdy), 32'h0);
        check("mrst_vld", 32'(bus.out_vld), 32'h0);
        check("mrst_data", 32'(bus.out_data), 32'h0);
        check("mrst_gidx", 32'(bus.grant_idx), 32'h0);
        cyc(4'b0110, idx_data(8'h40), 1'b1, 1'b0);
        check("mrst_first", 32'(bus.grant_idx), 32'h1);
        check("mrst_fdata", 32'(bus.out_data), 32'h41);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [N*W-1:0] rd;
            rd = N*W'($urandom);
            cyc(N'($urandom), rd, ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 63) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_arbiter_rr.md
# mux_arbiter_rr

Round-robin arbiter that shares a single N:1 data mux among N valid/ready requesters and drives one registered output channel. Each cycle it picks at most one valid requester, steers that requester's data through the mux into an output register, and acknowledges only that requester. It sits in front of any shared single-consumer resource that was previously driven by a plain mux with a hand-wired select.

## Interface
- `N`, 4: number of requesters, ≥2
- `W`, 8: data width per requester
- `clk`  input  1  clock, all state on rising edge
- `rst`  input  1  synchronous, active-high reset
- `req_vld`  input  N  requester i has data
- `req_data`  input  N*W  requester i data in bits [i*W +: W]
- `req_rdy`  output  N  one-hot or zero; transfer from i when `req_vld[i] & req_rdy[i]`
- `out_vld`  output  1  output register holds data
- `out_data`  output  W  registered mux output
- `out_rdy`  input  1  consumer accepts when `out_vld & out_rdy`
- `grant_idx`  output  $clog2(N)  index of the requester whose data is in the output register

## Operation
- State: output register (`out_vld`, `out_data`, `grant_idx`) and round-robin pointer `last` (index of the most recent grant).
- `load_en = !out_vld || out_rdy`: the register is empty or drains this cycle.
- Selection: the first i with `req_vld[i]=1`, scanning `last+1, last+2, …` modulo N. Wrap from N-1 to 0.
- `req_rdy[sel] = load_en & any(req_vld)`; all other bits 0. `req_rdy` is combinational from `req_vld`, `out_vld` and `out_rdy`. Upstream must not derive `req_vld` from `req_rdy`.
- On a transfer: `out_data <= req_data[sel]`, `grant_idx <= sel`, `last <= sel`, `out_vld <= 1`.
- On `load_en` with no valid requester: `out_vld <= 0`. `out_data`, `grant_idx` and `last` hold.
- When `!load_en`, everything holds. `req_vld` may change without effect, and the stored data is not overwritten.
- Simultaneous drain and load in one cycle is the normal case and gives back-to-back throughput of 1 word per cycle.
- A requester that drops `req_vld` before it is granted is skipped with no penalty. There is no lock or hold across cycles; each transfer is arbitrated independently.

## Timing
- Reset values: `out_vld=0`, `out_data=0`, `grant_idx=0`, `last=N-1`, so the first grant after reset favours index 0. `req_rdy` is 0 in the reset cycle.
- Reset mid-operation drops any word held in the output register; it is not delivered.
- Latency is 1 cycle from the `req_vld&req_rdy` edge to `out_vld=1` with that data.
- Throughput is 1 transfer per cycle while `out_rdy=1`.
- Fairness: with all N requesters continuously valid and `out_rdy=1`, each requester is granted exactly once every N cycles.
- While `out_vld=1`, `out_data` and `grant_idx` stay stable until `out_rdy` is seen high.

## Configuration
- `MUX_ARB_FIXED_PRIO_EN`
- Defined: selection is fixed priority, the lowest valid index always wins, and `last` is not implemented. Starvation of high indices is allowed.
- Undefined (default): round-robin as described above.
- Handshake, latency and reset behaviour are identical in both builds.

## Test plan
- Single requester: `req_vld=0b0100`, `req_data[2]=8'hA5`, `out_rdy=1` → `req_rdy=0b0100` in the same cycle. Next cycle `out_vld=1`, `out_data=8'hA5`, `grant_idx=2`.
- All valid, `out_rdy=1` for 8 cycles, data = index → grants 0,1,2,3,0,1,2,3 back to back with `out_vld` continuously high. With `MUX_ARB_FIXED_PRIO_EN` → grants 0 every cycle.
- Backpressure: load a word from requester 1, then hold `out_rdy=0` for 3 cycles with `req_vld=0b1111` → `req_rdy=0`, and `out_data`/`grant_idx=1` stay stable. Raising `out_rdy` → the next grant is 2 and loads in that same cycle.
- Wrap and skip: `last=3`, `req_vld=0b1010` → grant 1, then grant 3, then grant 1.
- Drain with no requesters: `out_vld=1`, `out_rdy=1`, `req_vld=0` → `out_vld=0` next cycle and `last` unchanged.
- Reset mid-stream: `rst=1` for 1 cycle while `out_vld=1` → next cycle `out_vld=0`, `out_data=0`, `grant_idx=0`, and the first grant afterwards goes to the lowest valid index.
